mem_port_arbiter: RTL and testbench

- Shares one single-ported synchronous memory between the instruction-fetch requester (IF) and the MEM-stage data requester (D).
- Sequences each access through a small FSM: post-reset startup wait, idle/issue, and read-latency wait.
- Returns read data to the owning requester and drives per-requester stall lines to the hazard logic.
- Sits between the pipeline's IF/MEM stages and the memory macro.

---
 rtl/mem_port_arbiter_pkg.sv | 5 +
 rtl/mem_arb_lat_cnt.sv | 19 +
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state and owner types for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_STARTUP, ARB_IDLE, ARB_RDWAIT} mem_arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} mem_owner_t;
endpackage

// File: rtl/mem_arb_lat_cnt.sv
// mem_arb_lat_cnt: up-counter with clear/load-to-one and terminal-count compare
module mem_arb_lat_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic         i_inc,
  input  logic [W-1:0] i_tc,
  output logic         o_hit
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst_n || i_clr) r_cnt <= '0;
    else if (i_ld) r_cnt <= W'(1);
    else if (i_inc) r_cnt <= r_cnt + W'(1);
  assign o_hit = r_cnt == i_tc;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between instruction fetch and data access
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 2,
  parameter int STARTUP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_stall,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam logic [2:0] LAT_TC = 3'(RD_LAT);
  localparam logic [3:0] SU_TC  = 4'(STARTUP_CYC - 1);
  mem_arb_state_t r_state, w_state_nxt;
  mem_owner_t     r_owner, w_owner_nxt, r_last, w_last_nxt;
  logic r_kill, w_kill_nxt;
  logic w_su_hit, w_lat_hit, w_idle, w_gnt_d, w_gnt_if, w_wr_issue, w_rd_issue, w_resp;
  mem_arb_lat_cnt #(.W(4)) u_su_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (1'b0),
    .i_ld  (1'b0),
    .i_inc (r_state == ARB_STARTUP),
    .i_tc  (SU_TC),
    .o_hit (w_su_hit)
  );
  mem_arb_lat_cnt #(.W(3)) u_lat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_resp),
    .i_ld  (w_rd_issue),
    .i_inc (r_state == ARB_RDWAIT),
    .i_tc  (LAT_TC),
    .o_hit (w_lat_hit)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= ARB_STARTUP;
      r_owner <= OWN_IF;
      r_last  <= OWN_IF;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_kill  <= w_kill_nxt;
    end
  // outputs are gated by rst_n so a reset cycle never issues or returns data
  always_comb begin
    w_idle      = rst_n && r_state == ARB_IDLE;
    w_gnt_d     = w_idle && d_req && (!if_req || r_last == OWN_IF);
    w_gnt_if    = w_idle && if_req && !w_gnt_d;
    w_wr_issue  = w_gnt_d && d_we;
    w_rd_issue  = w_gnt_if || (w_gnt_d && !d_we);
    w_resp      = rst_n && r_state == ARB_RDWAIT && w_lat_hit;
    w_state_nxt = ((r_state == ARB_STARTUP && w_su_hit) || w_resp) ? ARB_IDLE :
                  w_rd_issue ? ARB_RDWAIT : r_state;
    w_owner_nxt = w_rd_issue ? (w_gnt_d ? OWN_D : OWN_IF) : r_owner;
    w_last_nxt  = (w_idle && if_req && d_req) ? (w_gnt_d ? OWN_D : OWN_IF) : r_last;
    w_kill_nxt  = !w_resp && (r_kill || (if_flush &&
                  (w_gnt_if || (r_state == ARB_RDWAIT && r_owner == OWN_IF))));
    if_rvalid   = w_resp && r_owner == OWN_IF && !r_kill && !if_flush;
    d_rvalid    = w_resp && r_owner == OWN_D;
    if_rdata    = if_rvalid ? mem_rdata : '0;
    d_rdata     = d_rvalid ? mem_rdata : '0;
    if_stall    = if_req && !if_rvalid;
    d_stall     = d_req && !(d_rvalid || w_wr_issue);
    mem_cs      = w_gnt_d || w_gnt_if;
    mem_we      = w_wr_issue;
    mem_addr    = w_gnt_d ? d_addr : w_gnt_if ? if_addr : '0;
    mem_wdata   = w_wr_issue ? d_wdata : '0;
    busy        = rst_n && r_state != ARB_IDLE;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tests of the memory port arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_rvalid, if_stall, d_rvalid, d_stall, mem_cs, mem_we, busy;
  int total = 0, bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .STARTUP_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_stall(d_stall),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    if_req = 1'b1; if_addr = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL rst_cs got=%0h exp=0", mem_cs); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL rst_if_stall got=%0h exp=1", if_stall); end
    total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0h%0h exp=00", if_rvalid, d_rvalid); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL startup_cs%0d got=%0h exp=0", i, mem_cs); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL startup_busy%0d got=%0h exp=1", i, busy); end
    end
    @(negedge clk); #1;
    total++; if (mem_cs !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL startup_issue cs/we got=%0h/%0h exp=1/0", mem_cs, mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL startup_issue_addr got=%h exp=0", mem_addr); end
    @(negedge clk); #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL startup_wait_rvalid got=%0h exp=0", if_rvalid); end
    @(negedge clk); mem_rdata = 32'hA5A5_0001; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL startup_resp got=%0h/%h exp=1/a5a50001", if_rvalid, if_rdata); end
    @(negedge clk); if_req = 1'b0; mem_rdata = '0; #1;
    total++; if (busy !== 1'b0 || mem_cs !== 1'b0) begin bad++; $display("FAIL startup_idle busy/cs got=%0h/%0h exp=0/0", busy, mem_cs); end
  endtask

  task automatic test_single_fetch;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h4; #1;
    total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h4) begin bad++; $display("FAIL fetch_issue got=%0h/%h exp=1/4", mem_cs, mem_addr); end
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_t got=%0h exp=1", if_stall); end
    @(negedge clk); mem_rdata = 32'hFFFF_FFFF; #1;
    total++; if (if_stall !== 1'b1 || if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin bad++; $display("FAIL fetch_t1 stall/rv/rd got=%0h/%0h/%h exp=1/0/0", if_stall, if_rvalid, if_rdata); end
    total++; if (mem_cs !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL fetch_t1 cs/busy got=%0h/%0h exp=0/1", mem_cs, busy); end
    @(negedge clk); mem_rdata = 32'h13; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13) begin bad++; $display("FAIL fetch_resp got=%0h/%h exp=1/13", if_rvalid, if_rdata); end
    total++; if (if_stall !== 1'b0 || mem_cs !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_resp stall/cs/drv got=%0h/%0h/%0h exp=0/0/0", if_stall, mem_cs, d_rvalid); end
    @(negedge clk); if_req = 1'b0; mem_rdata = '0; #1;
    total++; if (if_rvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL fetch_after rv/busy got=%0h/%0h exp=0/0", if_rvalid, busy); end
  endtask

  task automatic test_round_robin;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; #1;
    total++; if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin bad++; $display("FAIL rr1_grant got=%0h/%0h/%h exp=1/0/100", mem_cs, mem_we, mem_addr); end
    total++; if (d_stall !== 1'b1 || if_stall !== 1'b1) begin bad++; $display("FAIL rr1_stalls got=%0h/%0h exp=1/1", d_stall, if_stall); end
    @(negedge clk); #1;
    total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL rr1_wait_cs got=%0h exp=0", mem_cs); end
    @(negedge clk); mem_rdata = 32'h77; #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h77 || d_stall !== 1'b0) begin bad++; $display("FAIL rr1_dresp got=%0h/%h/%0h exp=1/77/0", d_rvalid, d_rdata, d_stall); end
    total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || mem_cs !== 1'b0) begin bad++; $display("FAIL rr1_if_quiet got=%0h/%h/%0h exp=0/0/0", if_rvalid, if_rdata, mem_cs); end
    @(negedge clk); d_req = 1'b0; mem_rdata = '0; #1;
    total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h40 || d_rvalid !== 1'b0) begin bad++; $display("FAIL rr1_if_issue got=%0h/%h/%0h exp=1/40/0", mem_cs, mem_addr, d_rvalid); end
    @(negedge clk); #1;
    @(negedge clk); mem_rdata = 32'h55; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h55) begin bad++; $display("FAIL rr1_if_resp got=%0h/%h exp=1/55", if_rvalid, if_rdata); end
    @(negedge clk); mem_rdata = '0; if_addr = 32'h44; d_req = 1'b1; d_addr = 32'h104; #1;
    total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h44) begin bad++; $display("FAIL rr2_grant_if got=%0h/%h exp=1/44", mem_cs, mem_addr); end
    total++; if (d_stall !== 1'b1) begin bad++; $display("FAIL rr2_d_stall got=%0h exp=1", d_stall); end
    @(negedge clk); #1;
    @(negedge clk); mem_rdata = 32'h66; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h66 || d_rvalid !== 1'b0) begin bad++; $display("FAIL rr2_if_resp got=%0h/%h/%0h exp=1/66/0", if_rvalid, if_rdata, d_rvalid); end
    @(negedge clk); if_req = 1'b0; mem_rdata = '0; #1;
    total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h104) begin bad++; $display("FAIL rr2_d_issue got=%0h/%h exp=1/104", mem_cs, mem_addr); end
    @(negedge clk); #1;
    @(negedge clk); mem_rdata = 32'h88; #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h88) begin bad++; $display("FAIL rr2_d_resp got=%0h/%h exp=1/88", d_rvalid, d_rdata); end
    @(negedge clk); d_req = 1'b0; mem_rdata = '0; #1;
  endtask

  task automatic test_write;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; #1;
    total++; if (mem_cs !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL wr_cs_we got=%0h/%0h exp=1/1", mem_cs, mem_we); end
    total++; if (mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_addr_data got=%h/%h exp=200/deadbeef", mem_addr, mem_wdata); end
    total++; if (d_stall !== 1'b0 || if_stall !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL wr_stall_busy got=%0h/%0h/%0h exp=0/1/0", d_stall, if_stall, busy); end
    @(negedge clk); d_req = 1'b0; d_we = 1'b0; d_wdata = '0; #1;
    total++; if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8 || mem_wdata !== 32'h0) begin bad++; $display("FAIL wr_next_if got=%0h/%0h/%h/%h exp=1/0/8/0", mem_cs, mem_we, mem_addr, mem_wdata); end
    @(negedge clk); #1;
    @(negedge clk); mem_rdata = 32'h99; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h99) begin bad++; $display("FAIL wr_if_resp got=%0h/%h exp=1/99", if_rvalid, if_rdata); end
    @(negedge clk); if_req = 1'b0; mem_rdata = '0; #1;
  endtask

  task automatic test_flush;
    @(negedge clk); if_req = 1'b1; if_addr = 32'hC; #1;
    total++; if (mem_cs !== 1'b1 || mem_addr !== 32'hC) begin bad++; $display("FAIL fl_issue got=%0h/%h exp=1/c", mem_cs, mem_addr); end
    @(negedge clk); if_flush = 1'b1; #1;
    @(negedge clk); if_flush = 1'b0; mem_rdata = 32'h12; #1;
    total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin bad++; $display("FAIL fl_killed got=%0h/%h exp=0/0", if_rvalid, if_rdata); end
    total++; if (busy !== 1'b1 || if_stall !== 1'b1) begin bad++; $display("FAIL fl_resp_busy_stall got=%0h/%0h exp=1/1", busy, if_stall); end
    @(negedge clk); if_addr = 32'h20; mem_rdata = '0; #1;
    total++; if (busy !== 1'b0 || mem_cs !== 1'b1 || mem_addr !== 32'h20) begin bad++; $display("FAIL fl_reissue got=%0h/%0h/%h exp=0/1/20", busy, mem_cs, mem_addr); end
    @(negedge clk); #1;
    @(negedge clk); mem_rdata = 32'h21; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h21) begin bad++; $display("FAIL fl_kill_cleared got=%0h/%h exp=1/21", if_rvalid, if_rdata); end
    @(negedge clk); if_addr = 32'h24; mem_rdata = '0; #1;
    @(negedge clk); #1;
    @(negedge clk); if_flush = 1'b1; mem_rdata = 32'h25; #1;
    total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin bad++; $display("FAIL fl_resp_cycle got=%0h/%h exp=0/0", if_rvalid, if_rdata); end
    @(negedge clk); if_flush = 1'b0; if_req = 1'b0; mem_rdata = '0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fl_resp_cycle_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; #1;
    total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h300) begin bad++; $display("FAIL rm_issue got=%0h/%h exp=1/300", mem_cs, mem_addr); end
    @(negedge clk); rst_n = 1'b0; #1;
    total++; if (mem_cs !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rm_mem_zero got=%0h/%0h/%h/%h exp=0/0/0/0", mem_cs, mem_we, mem_addr, mem_wdata); end
    @(negedge clk); rst_n = 1'b1; mem_rdata = 32'hBAD; #1;
    total++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || d_stall !== 1'b1) begin bad++; $display("FAIL rm_no_resp got=%0h/%h/%0h exp=0/0/1", d_rvalid, d_rdata, d_stall); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); mem_rdata = '0; #1;
      total++; if (mem_cs !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL rm_startup%0d cs/rv got=%0h/%0h exp=0/0", i, mem_cs, d_rvalid); end
    end
    @(negedge clk); #1;
    total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h300) begin bad++; $display("FAIL rm_reissue got=%0h/%h exp=1/300", mem_cs, mem_addr); end
    @(negedge clk); #1;
    @(negedge clk); mem_rdata = 32'h31; #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h31) begin bad++; $display("FAIL rm_resp got=%0h/%h exp=1/31", d_rvalid, d_rdata); end
    @(negedge clk); d_req = 1'b0; mem_rdata = '0; #1;
  endtask

  initial begin
    test_reset;
    test_single_fetch;
    test_round_robin;
    test_write;
    test_flush;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
